// File: rtl/flght_pkg.sv
// Shared types, widths and saturation helpers for the flight mixer pipeline.
package flght_pkg;

   localparam int unsigned ERR_W   = 10;
   localparam int unsigned DDIFF_W = 7;
   localparam int unsigned DTERM_W = 12;
   localparam int unsigned MIX_W   = 13;

   localparam logic signed [ERR_W-1:0]   ErrMax   = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic signed [ERR_W-1:0]   ErrMin   = {1'b1, {(ERR_W-1){1'b0}}};
   localparam logic signed [DDIFF_W-1:0] DdiffMax = {1'b0, {(DDIFF_W-1){1'b1}}};
   localparam logic signed [DDIFF_W-1:0] DdiffMin = {1'b1, {(DDIFF_W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRamp, StCal, StRun} state_e;

   // Clip a raw 17-bit angle error to the signed error width.
   function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [16:0] v);
      if (v > 17'(ErrMax)) return ErrMax;
      if (v < 17'(ErrMin)) return ErrMin;
      return v[ERR_W-1:0];
   endfunction

   // Clip an error difference to the signed D-difference width.
   function automatic logic signed [DDIFF_W-1:0] sat_ddiff(input logic signed [ERR_W:0] v);
      if (v > (ERR_W+1)'(DdiffMax)) return DdiffMax;
      if (v < (ERR_W+1)'(DdiffMin)) return DdiffMin;
      return v[DDIFF_W-1:0];
   endfunction

endpackage

// File: rtl/pd_axis.sv
// One PD axis: S1 saturates the error and keeps the D history, S2 forms P and D terms.
module pd_axis
   import flght_pkg::*;
#(
   parameter int unsigned D_QUEUE_DEPTH = 12,
   parameter int unsigned D_COEFF       = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_vld,
   input  logic                      i_cal,
   input  logic signed [15:0]        i_desired,
   input  logic signed [15:0]        i_actual,
   output logic signed [ERR_W-1:0]   o_pterm,
   output logic signed [DTERM_W-1:0] o_dterm
);

   logic signed [16:0]         w_err;
   logic signed [ERR_W-1:0]    w_err_sat;
   logic signed [ERR_W:0]      w_diff;
   logic signed [DTERM_W-1:0]  w_d_ext;
   logic signed [DTERM_W-1:0]  w_coeff;
   logic signed [ERR_W-1:0]    r_hist [D_QUEUE_DEPTH];
   logic signed [ERR_W-1:0]    r_err_sat;
   logic signed [DDIFF_W-1:0]  r_d_diff;
   logic signed [ERR_W-1:0]    r_pterm;
   logic signed [DTERM_W-1:0]  r_dterm;

   assign w_err     = 17'(i_actual) - 17'(i_desired);
   assign w_err_sat = sat_err(w_err);
   assign w_diff    = (ERR_W+1)'(w_err_sat) - (ERR_W+1)'(r_hist[D_QUEUE_DEPTH-1]);
   assign w_d_ext   = DTERM_W'(r_d_diff);
   assign w_coeff   = DTERM_W'(D_COEFF);

   // S1: capture error and difference on vld; history is flushed while calibrating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_sat <= '0;
         r_d_diff  <= '0;
         for (int i = 0; i < D_QUEUE_DEPTH; i++) r_hist[i] <= '0;
      end else begin
         if (i_vld) begin
            r_err_sat <= w_err_sat;
            r_d_diff  <= sat_ddiff(w_diff);
         end
         if (i_cal) begin
            for (int i = 0; i < D_QUEUE_DEPTH; i++) r_hist[i] <= '0;
         end else if (i_vld) begin
            r_hist[0] <= w_err_sat;
            for (int i = 1; i < D_QUEUE_DEPTH; i++) r_hist[i] <= r_hist[i-1];
         end
      end
   end

   // S2: P = 5/8 of the error (two shifts), D = difference times coefficient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pterm <= '0;
         r_dterm <= '0;
      end else begin
         r_pterm <= (r_err_sat >>> 1) + (r_err_sat >>> 3);
         r_dterm <= w_d_ext * w_coeff;
      end
   end

   assign o_pterm = r_pterm;
   assign o_dterm = r_dterm;

endmodule

// File: rtl/flght_mixer_pipe.sv
// Flight mixer: three PD axes, 4-motor mix with clamp, slew limit and calibration ramp FSM.
module flght_mixer_pipe
   import flght_pkg::*;
#(
   parameter int unsigned      SPD_W         = 11,
   parameter int unsigned      THRST_W       = 9,
   parameter int unsigned      D_QUEUE_DEPTH = 12,
   parameter int unsigned      D_COEFF       = 7,
   parameter logic [SPD_W-1:0] CAL_SPEED     = 11'h290,
   parameter logic [SPD_W-1:0] MIN_RUN_SPEED = 11'h2C0,
   parameter logic [SPD_W-1:0] RAMP_STEP     = 11'h040,
   parameter logic [SPD_W-1:0] SLEW_MAX      = 11'h100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_vld,
   input  logic               i_inertial_cal,
   input  logic signed [15:0] i_d_ptch,
   input  logic signed [15:0] i_d_roll,
   input  logic signed [15:0] i_d_yaw,
   input  logic signed [15:0] i_ptch,
   input  logic signed [15:0] i_roll,
   input  logic signed [15:0] i_yaw,
   input  logic [THRST_W-1:0] i_thrst,
   output logic [SPD_W-1:0]   o_frnt_spd,
   output logic [SPD_W-1:0]   o_bck_spd,
   output logic [SPD_W-1:0]   o_lft_spd,
   output logic [SPD_W-1:0]   o_rght_spd,
   output logic               o_spd_vld
);

   localparam logic signed [MIX_W-1:0] SpdMax = {{(MIX_W-SPD_W){1'b0}}, {SPD_W{1'b1}}};

   // Axis order: 0 pitch, 1 roll, 2 yaw. Motor order: 0 front, 1 back, 2 left, 3 right.
   logic signed [ERR_W-1:0]   w_pterm [3];
   logic signed [DTERM_W-1:0] w_dterm [3];
   logic signed [MIX_W-1:0]   w_tot [3];
   logic signed [MIX_W-1:0]   w_base;
   logic signed [MIX_W-1:0]   w_mix [4];
   logic [SPD_W-1:0]          w_tgt [4];
   logic [SPD_W-1:0]          w_slew [4];
   logic [SPD_W-1:0]          w_min_spd;
   logic [SPD_W-1:0]          w_ramp_base;
   logic [SPD_W:0]            w_ramp_sum;
   logic [SPD_W-1:0]          w_ramp_nxt;
   state_e                    w_state_nxt;

   state_e                    r_state;
   state_e                    r_st2;
   logic [SPD_W-1:0]          r_ramp;
   logic [SPD_W-1:0]          r_ramp2;
   logic [THRST_W-1:0]        r_thrst1;
   logic [THRST_W-1:0]        r_thrst2;
   logic                      r_vld1;
   logic                      r_vld2;
   logic [SPD_W-1:0]          r_spd [4];
   logic                      r_spd_vld;

   function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [MIX_W-1:0] v);
      if (v[MIX_W-1]) return '0;
      if (v > SpdMax) return '1;
      return v[SPD_W-1:0];
   endfunction

   pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_ptch (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_cal(i_inertial_cal),
      .i_desired(i_d_ptch), .i_actual(i_ptch), .o_pterm(w_pterm[0]), .o_dterm(w_dterm[0])
   );
   pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_roll (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_cal(i_inertial_cal),
      .i_desired(i_d_roll), .i_actual(i_roll), .o_pterm(w_pterm[1]), .o_dterm(w_dterm[1])
   );
   pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_COEFF(D_COEFF)) u_yaw (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_cal(i_inertial_cal),
      .i_desired(i_d_yaw), .i_actual(i_yaw), .o_pterm(w_pterm[2]), .o_dterm(w_dterm[2])
   );

   // Slowest motor speed; a ramp re-entered from RUN starts from here.
   always_comb begin
      w_min_spd = r_spd[0];
      for (int i = 1; i < 4; i++) begin
         if (r_spd[i] < w_min_spd) w_min_spd = r_spd[i];
      end
   end

   // FSM next state and ramp value; both are decided as a sample enters S1.
   always_comb begin
      w_state_nxt = r_state;
      w_ramp_base = (r_state == StRamp) ? r_ramp : w_min_spd;
      w_ramp_sum  = {1'b0, w_ramp_base} + {1'b0, RAMP_STEP};
      w_ramp_nxt  = (w_ramp_sum > {1'b0, CAL_SPEED}) ? CAL_SPEED : w_ramp_sum[SPD_W-1:0];
      case (r_state)
         StIdle:  w_state_nxt = i_inertial_cal ? StRamp : StRun;
         StRamp: begin
            if (!i_inertial_cal)              w_state_nxt = StRun;
            else if (w_ramp_nxt == CAL_SPEED) w_state_nxt = StCal;
         end
         StCal:   if (!i_inertial_cal) w_state_nxt = StRun;
         StRun:   if (i_inertial_cal) w_state_nxt = StRamp;
         default: w_state_nxt = StIdle;
      endcase
   end

   // FSM state register; also serves as the S1 copy of the sample's state and ramp value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_ramp  <= '0;
      end else if (i_vld) begin
         r_state <= w_state_nxt;
         r_ramp  <= w_ramp_nxt;
      end
   end

   // Valid bits and per-sample side data travel alongside the PD stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld1   <= 1'b0;
         r_vld2   <= 1'b0;
         r_thrst1 <= '0;
         r_thrst2 <= '0;
         r_st2    <= StIdle;
         r_ramp2  <= '0;
      end else begin
         r_vld1   <= i_vld;
         r_vld2   <= r_vld1;
         r_thrst2 <= r_thrst1;
         r_st2    <= r_state;
         r_ramp2  <= r_ramp;
         if (i_vld) r_thrst1 <= i_thrst;
      end
   end

   // S3 mix, clamp and per-motor slew limiting against the current output.
   always_comb begin
      w_base = MIX_W'(r_thrst2) + MIX_W'(MIN_RUN_SPEED);
      for (int a = 0; a < 3; a++) w_tot[a] = MIX_W'(w_pterm[a]) + MIX_W'(w_dterm[a]);
      w_mix[0] = w_base - w_tot[0] - w_tot[2];
      w_mix[1] = w_base + w_tot[0] - w_tot[2];
      w_mix[2] = w_base - w_tot[1] + w_tot[2];
      w_mix[3] = w_base + w_tot[1] + w_tot[2];
      for (int i = 0; i < 4; i++) begin
         w_tgt[i] = clamp_spd(w_mix[i]);
         if (SLEW_MAX == '0) begin
            w_slew[i] = w_tgt[i];
         end else if (w_tgt[i] > r_spd[i]) begin
            w_slew[i] = ((w_tgt[i] - r_spd[i]) > SLEW_MAX) ? r_spd[i] + SLEW_MAX : w_tgt[i];
         end else begin
            w_slew[i] = ((r_spd[i] - w_tgt[i]) > SLEW_MAX) ? r_spd[i] - SLEW_MAX : w_tgt[i];
         end
      end
   end

   // S3 output registers, selected by the state the sample carried from S1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_spd[i] <= '0;
         r_spd_vld <= 1'b0;
      end else begin
         r_spd_vld <= r_vld2;
         if (r_vld2) begin
            for (int i = 0; i < 4; i++) begin
               case (r_st2)
                  StRamp:  r_spd[i] <= r_ramp2;
                  StCal:   r_spd[i] <= CAL_SPEED;
                  StRun:   r_spd[i] <= w_slew[i];
                  default: r_spd[i] <= '0;
               endcase
            end
         end
      end
   end

   assign o_frnt_spd = r_spd[0];
   assign o_bck_spd  = r_spd[1];
   assign o_lft_spd  = r_spd[2];
   assign o_rght_spd = r_spd[3];
   assign o_spd_vld  = r_spd_vld;

endmodule
